// File: rtl/nes_controller_emulator.sv
// rtl/nes_controller_emulator.sv - NES pad responder: answers console LATCH/PULSE with 8 active-low button bits on DATA.
module nes_controller_emulator #(
  parameter logic        PAD_LEVEL = 1'b0,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       nes_latch,
  input  logic       nes_pulse,
  output logic       nes_data,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] bit_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  sr, sr_next;
  logic [3:0]  bit_count_next;
  logic [15:0] idle_cnt, idle_next;
  logic        frame_done_next, nes_data_next, busy_next;

  logic latch_s1, latch_s2, latch_s3;
  logic pulse_s1, pulse_s2, pulse_s3;
  logic latch_fall, pulse_rise;

  // Console signals are asynchronous; s3 only exists to give a one-cycle edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_s3 <= 1'b0;
      pulse_s1 <= 1'b0;
      pulse_s2 <= 1'b0;
      pulse_s3 <= 1'b0;
    end else begin
      latch_s1 <= nes_latch;
      latch_s2 <= latch_s1;
      latch_s3 <= latch_s2;
      pulse_s1 <= nes_pulse;
      pulse_s2 <= pulse_s1;
      pulse_s3 <= pulse_s2;
    end
  end

  assign latch_fall = ~latch_s2 & latch_s3;
  assign pulse_rise = pulse_s2 & ~pulse_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sr         <= 8'hFF;
      bit_count  <= 4'd0;
      idle_cnt   <= 16'd0;
      frame_done <= 1'b0;
      nes_data   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      bit_count  <= bit_count_next;
      idle_cnt   <= idle_next;
      frame_done <= frame_done_next;
      nes_data   <= nes_data_next;
      busy       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state;
    sr_next         = sr;
    bit_count_next  = bit_count;
    idle_next       = idle_cnt;
    frame_done_next = 1'b0;

    // A high latch behaves like the 4021 parallel load and overrides everything else.
    if (latch_s2) begin
      state_next     = S_LOAD;
      sr_next        = ~buttons;
      bit_count_next = 4'd0;
      idle_next      = 16'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (latch_fall) begin
            state_next = S_SHIFT;
            idle_next  = 16'd0;
          end
        end
        S_SHIFT: begin
          if (pulse_rise) begin
            sr_next        = {PAD_LEVEL, sr[7:1]};
            bit_count_next = bit_count + 4'd1;
            idle_next      = 16'd0;
            if (bit_count == 4'd7) begin
              state_next      = S_DONE;
              frame_done_next = 1'b1;
            end
          end else if (idle_cnt == TIMEOUT - 16'd1) begin
            state_next     = S_IDLE;
            bit_count_next = 4'd0;
            idle_next      = 16'd0;
          end else begin
            idle_next = idle_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end

    case (state_next)
      S_IDLE:  nes_data_next = 1'b1;
      S_DONE:  nes_data_next = PAD_LEVEL;
      default: nes_data_next = sr_next[0];
    endcase
    busy_next = (state_next == S_LOAD) || (state_next == S_SHIFT);
  end

endmodule
